// File: rtl/vga_pkg.sv
// Shared types and default 640x480@60 raster timing for the VGA output stage.
// The sync struct is what travels down the delay line alongside the colour path.
package vga_pkg;

    localparam int VGA_H_ACTIVE = 640;
    localparam int VGA_H_FP     = 16;
    localparam int VGA_H_SYNC   = 96;
    localparam int VGA_H_BP     = 48;
    localparam int VGA_V_ACTIVE = 480;
    localparam int VGA_V_FP     = 10;
    localparam int VGA_V_SYNC   = 2;
    localparam int VGA_V_BP     = 33;

    localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
    localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

    typedef logic [9:0] vga_coord_t;

    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } vga_sync_t;

    // Blank, both syncs deasserted: what the connector sees while idle.
    localparam vga_sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, active: 1'b0};

    function automatic logic in_window(input vga_coord_t c,
                                       input vga_coord_t lo,
                                       input vga_coord_t hi);
        return (c >= lo) && (c < hi);
    endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Enable-gated shift register that lines up {hs, vs, active} with the pixel
// coming back from the colour path. DEPTH = 0 is a straight wire.
module vga_sync_delay
    import vga_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      en,
    input  vga_sync_t d,
    output vga_sync_t q
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic unused_ctrl;
            assign unused_ctrl = clk ^ rst_n ^ en;
            assign q = d;
        end else begin : g_shift
            vga_sync_t stage [DEPTH];

            // NOTE: non-blocking assignments let every stage sample the old value
            // of its neighbour, which is what makes this a shift rather than a copy.
            // NOTE: unlike a RAM, these stages are reset: stale sync bits would
            // otherwise reach the connector as a partial pulse after reset.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= SYNC_IDLE;
                end else if (en) begin
                    stage[0] <= d;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign q = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_out_stage.sv
// Raster counters, sync decode and the registered VGA connector outputs.
// Sync/active are delayed to match the colour-path latency of the returned pixel.
module vga_out_stage
    import vga_pkg::*;
#(
    parameter int H_ACTIVE    = VGA_H_ACTIVE,
    parameter int H_FP        = VGA_H_FP,
    parameter int H_SYNC      = VGA_H_SYNC,
    parameter int H_BP        = VGA_H_BP,
    parameter int V_ACTIVE    = VGA_V_ACTIVE,
    parameter int V_FP        = VGA_V_FP,
    parameter int V_SYNC      = VGA_V_SYNC,
    parameter int V_BP        = VGA_V_BP,
    parameter int PIX_LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        pix_en,
    output vga_coord_t  hcount,
    output vga_coord_t  vcount,
    input  logic [23:0] pix_in,
    output logic [3:0]  vga_r,
    output logic [3:0]  vga_g,
    output logic [3:0]  vga_b,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam vga_coord_t H_LAST     = vga_coord_t'(H_TOTAL - 1);
    localparam vga_coord_t V_LAST     = vga_coord_t'(V_TOTAL - 1);
    localparam vga_coord_t H_ACT_END  = vga_coord_t'(H_ACTIVE);
    localparam vga_coord_t V_ACT_END  = vga_coord_t'(V_ACTIVE);
    localparam vga_coord_t H_SYNC_BEG = vga_coord_t'(H_ACTIVE + H_FP);
    localparam vga_coord_t H_SYNC_END = vga_coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam vga_coord_t V_SYNC_BEG = vga_coord_t'(V_ACTIVE + V_FP);
    localparam vga_coord_t V_SYNC_END = vga_coord_t'(V_ACTIVE + V_FP + V_SYNC);

    vga_sync_t sync_raw;
    vga_sync_t sync_d;
    logic      h_wrap;
    logic      at_frame_end;
    logic      unused_lsbs;

    assign h_wrap       = (hcount == H_LAST);
    assign at_frame_end = h_wrap && (vcount == V_LAST);

    // Only the top nibble of each colour reaches the 4-bit DAC.
    assign unused_lsbs = ^{pix_in[19:16], pix_in[11:8], pix_in[3:0]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount <= '0;
            vcount <= '0;
        end else if (pix_en) begin
            if (h_wrap) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + vga_coord_t'(1);
            end else begin
                hcount <= hcount + vga_coord_t'(1);
            end
        end
    end

    // NOTE: every field gets a default before the decode, so no path through
    // this block can leave sync_raw unassigned and infer a latch.
    always_comb begin
        sync_raw        = SYNC_IDLE;
        sync_raw.active = (hcount < H_ACT_END) && (vcount < V_ACT_END);
        sync_raw.hs     = !in_window(hcount, H_SYNC_BEG, H_SYNC_END);
        sync_raw.vs     = !in_window(vcount, V_SYNC_BEG, V_SYNC_END);
    end

    vga_sync_delay #(
        .DEPTH (PIX_LATENCY)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_en),
        .d     (sync_raw),
        .q     (sync_d)
    );

    // Connector register: colour is forced to black outside the visible area.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vga_r       <= '0;
            vga_g       <= '0;
            vga_b       <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_en && at_frame_end;
            if (pix_en) begin
                vga_r  <= sync_d.active ? pix_in[23:20] : 4'h0;
                vga_g  <= sync_d.active ? pix_in[15:12] : 4'h0;
                vga_b  <= sync_d.active ? pix_in[7:4]   : 4'h0;
                vga_hs <= sync_d.hs;
                vga_vs <= sync_d.vs;
            end
        end
    end

endmodule
